sw_traceback_unit: RTL and testbench

- Reads back the per-cell traceback pointer matrix that the systolic PE array writes during Smith-Waterman scoring.
- Walks from a given end cell (normally the max-score cell) toward the origin and emits one alignment operation per step on a valid/ready stream.
- Sits after the PE array and pointer RAM, and in front of the CIGAR/host output logic.

---
 rtl/sw_traceback_pkg.sv | 13 +
 rtl/sw_traceback_unit.sv | 127 ++++++++++++
 tb/tb_sw_traceback_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_traceback_pkg.sv
// sw_traceback_pkg: pointer and op encodings plus FSM states shared by the traceback unit
// and the PE array writer that fills the pointer RAM.
package sw_traceback_pkg;
  localparam logic [2:0] PTR_DIAG = 3'd0;
  localparam logic [2:0] PTR_UP   = 3'd1;
  localparam logic [2:0] PTR_LEFT = 3'd2;
  localparam logic [2:0] PTR_STOP = 3'b111;
  typedef enum logic [1:0] {OP_MATCH = 2'd0, OP_INS = 2'd1, OP_DEL = 2'd2} op_e;
  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WAIT, ST_EMIT, ST_FIN} state_e;
  function automatic op_e ptr_to_op(logic [2:0] ptr);
    return ptr == PTR_DIAG ? OP_MATCH : ptr == PTR_UP ? OP_INS : OP_DEL;
  endfunction
endpackage

// File: rtl/sw_traceback_unit.sv
// sw_traceback_unit: walks the Smith-Waterman pointer matrix from an end cell toward the origin,
// emitting one alignment op per step on a valid/ready stream.
module sw_traceback_unit
  import sw_traceback_pkg::*;
#(
  parameter int QRY_LEN = 16,
  parameter int REF_LEN = 16,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [ROW_W-1:0] start_row_i,
  input  logic [COL_W-1:0] start_col_i,
  output logic             busy_o,
  output logic             mem_rd_en_o,
  output logic [ROW_W-1:0] mem_rd_row_o,
  output logic [COL_W-1:0] mem_rd_col_o,
  input  logic [2:0]       mem_rd_data_i,
  output logic             op_valid_o,
  input  logic             op_ready_i,
  output logic [1:0]       op_code_o,
  output logic [ROW_W-1:0] op_row_o,
  output logic [COL_W-1:0] op_col_o,
  output logic             done_o,
  output logic             err_o
);
  localparam int MAX_STEPS = QRY_LEN + REF_LEN;
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  state_e state_q;
  op_e op_code_q;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic busy_q, rd_en_q, valid_q, done_q, err_q;
  logic row_dec, col_dec, underflow, out_of_range, bad_ptr;
  always_comb begin
    row_dec = op_code_q != OP_DEL;
    col_dec = op_code_q != OP_INS;
    underflow = (row_dec && row_q == '0) || (col_dec && col_q == '0);
    row_d = row_q - ROW_W'(row_dec);
    col_d = col_q - COL_W'(col_dec);
    step_d = step_q + 1'b1;
    out_of_range = 32'(start_row_i) >= QRY_LEN || 32'(start_col_i) >= REF_LEN;
    bad_ptr = mem_rd_data_i > PTR_LEFT && mem_rd_data_i != PTR_STOP;
  end
  // Every output is a register; the current coordinates double as read address and op cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_code_q <= OP_MATCH;
      row_q     <= '0;
      col_q     <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_i) begin
          busy_q <= 1'b1;
          if (out_of_range) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q <= ST_READ;
            rd_en_q <= 1'b1;
            row_q   <= start_row_i;
            col_q   <= start_col_i;
            step_q  <= '0;
          end
        end
        ST_READ: state_q <= ST_WAIT;
        ST_WAIT: if (mem_rd_data_i == PTR_STOP || bad_ptr) begin
          state_q <= ST_FIN;
          done_q  <= 1'b1;
          err_q   <= bad_ptr;
        end else begin
          state_q   <= ST_EMIT;
          valid_q   <= 1'b1;
          op_code_q <= ptr_to_op(mem_rd_data_i);
        end
        ST_EMIT: if (op_ready_i) begin
          valid_q <= 1'b0;
          step_q  <= step_d;
          if (underflow) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
          end else begin
            row_q <= row_d;
            col_q <= col_d;
            if (32'(step_d) == MAX_STEPS) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_READ;
              rd_en_q <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign busy_o       = busy_q;
  assign mem_rd_en_o  = rd_en_q;
  assign mem_rd_row_o = row_q;
  assign mem_rd_col_o = col_q;
  assign op_valid_o   = valid_q;
  assign op_code_o    = op_code_q;
  assign op_row_o     = row_q;
  assign op_col_o     = col_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_sw_traceback_unit.sv
// tb_sw_traceback_unit: directed and randomized tracebacks checked against a walk model of the
// pointer matrix; a single negedge process compares every op, read and done against it.
module tb_sw_traceback_unit;
  localparam int QL = 16;
  localparam int RL = 16;
  localparam int RW = 5;
  localparam int CW = 5;
  typedef struct {int code; int row; int col;} op_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_i, op_ready_i = 1'b0;
  logic [RW-1:0] start_row_i, mem_rd_row_o, op_row_o;
  logic [CW-1:0] start_col_i, mem_rd_col_o, op_col_o;
  logic [2:0] mem_rd_data_i = 3'd0;
  logic busy_o, mem_rd_en_o, op_valid_o, done_o, err_o;
  logic [1:0] op_code_o;
  logic [2:0] mem [QL][RL];
  op_t exp_q[$];
  int exp_err, exp_reads;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int walk_rd, walk_done, first_rd, done_at, start_cyc;
  bit ready_rand = 1'b0, ready_hold = 1'b0;
  bit pv, pr, phs, prd, prd2;
  int pcode, prow, pcol;

  sw_traceback_unit #(.QRY_LEN(QL), .REF_LEN(RL), .ROW_W(RW), .COL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_row_i(start_row_i),
    .start_col_i(start_col_i), .busy_o(busy_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_rd_row_o(mem_rd_row_o), .mem_rd_col_o(mem_rd_col_o), .mem_rd_data_i(mem_rd_data_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .op_code_o(op_code_o),
    .op_row_o(op_row_o), .op_col_o(op_col_o), .done_o(done_o), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (mem_rd_en_o)
      mem_rd_data_i <= (mem_rd_row_o < RW'(QL) && mem_rd_col_o < CW'(RL)) ? mem[mem_rd_row_o][mem_rd_col_o] : 3'd7;
  always @(posedge clk) begin
    #1;
    op_ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : !ready_hold;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic fill_stop;
    for (int r = 0; r < QL; r++)
      for (int c = 0; c < RL; c++) mem[r][c] = 3'd7;
  endtask

  // Walk the matrix by the pointer rules: list of expected ops, cells read, and the err flag.
  task automatic model(input int r0, input int c0);
    int r, c, code;
    logic [2:0] p;
    bit dr, dc;
    exp_q.delete();
    exp_err = 0;
    exp_reads = 0;
    r = r0;
    c = c0;
    if (r >= QL || c >= RL) begin
      exp_err = 1;
      return;
    end
    for (int s = 0; s < 2 * (QL + RL); s++) begin
      exp_reads++;
      p = mem[r][c];
      if (p == 3'd7) break;
      if (p > 3'd2) begin
        exp_err = 1;
        break;
      end
      code = (p == 3'd0) ? 0 : (p == 3'd1) ? 1 : 2;
      exp_q.push_back('{code, r, c});
      dr = p != 3'd2;
      dc = p != 3'd1;
      if ((dr && r == 0) || (dc && c == 0)) break;
      if (exp_q.size() == QL + RL) begin
        exp_err = 1;
        break;
      end
      r -= int'(dr);
      c -= int'(dc);
    end
  endtask

  task automatic run_walk(input int r, input int c, input bit dbl, input int hold);
    model(r, c);
    walk_rd = 0;
    walk_done = 0;
    first_rd = -1;
    done_at = -1;
    ready_hold = hold > 0;
    step();
    start_row_i = RW'(r);
    start_col_i = CW'(c);
    start_i = 1'b1;
    start_cyc = cyc;
    step();
    start_i = dbl;
    step();
    start_i = 1'b0;
    if (hold > 0) begin
      for (int k = 0; k < 20 && !op_valid_o; k++) step();
      repeat (hold) step();
      chk("bp_valid", op_valid_o, 1);
      chk("bp_reads", walk_rd, 1);
      ready_hold = 1'b0;
    end
    for (int k = 0; k < 3000 && walk_done == 0; k++) step();
    chk("done_seen", walk_done, 1);
    step();
    chk("busy_after_done", busy_o, 0);
    repeat (3) step();
    chk("done_pulses", walk_done, 1);
    chk("reads_total", walk_rd, exp_reads);
  endtask

  always @(negedge clk) begin
    op_t e;
    if (!rst_n) begin
      pv = 0; pr = 0; phs = 0; prd = 0; prd2 = 0;
    end else begin
      if (mem_rd_en_o) begin
        walk_rd++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (op_valid_o) chk("rd_in_emit", mem_rd_en_o, 0);
      if (op_valid_o || mem_rd_en_o || done_o) chk("busy", busy_o, 1);
      if (pv && !pr) begin
        chk("hold_valid", op_valid_o, 1);
        chk("hold_code", op_code_o, pcode);
        chk("hold_row", op_row_o, prow);
        chk("hold_col", op_col_o, pcol);
      end
      if (phs) chk("after_hs", mem_rd_en_o | done_o, 1);
      if (prd) chk("rd_one_cycle", mem_rd_en_o, 0);
      if (prd2) chk("wait_result", op_valid_o | done_o, 1);
      if (op_valid_o && op_ready_i) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{-1, -1, -1};
        chk("op_code", op_code_o, e.code);
        chk("op_row", op_row_o, e.row);
        chk("op_col", op_col_o, e.col);
      end
      if (done_o) begin
        walk_done++;
        if (done_at < 0) done_at = cyc;
        if (walk_done == 1) begin
          chk("err", err_o, exp_err);
          chk("ops_left", exp_q.size(), 0);
          chk("reads_at_done", walk_rd, exp_reads);
        end
      end
      prd2 = prd;
      prd = mem_rd_en_o;
      pv = op_valid_o;
      pr = op_ready_i;
      phs = op_valid_o && op_ready_i;
      pcode = op_code_o;
      prow = op_row_o;
      pcol = op_col_o;
    end
  end

  initial begin
    int r, c, x;
    start_i = 0;
    start_row_i = '0;
    start_col_i = '0;
    fill_stop();
    #3 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy_o, 0);
    chk("rst_rd_en", mem_rd_en_o, 0);
    chk("rst_rd_row", mem_rd_row_o, 0);
    chk("rst_rd_col", mem_rd_col_o, 0);
    chk("rst_valid", op_valid_o, 0);
    chk("rst_code", op_code_o, 0);
    chk("rst_op_row", op_row_o, 0);
    chk("rst_op_col", op_col_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    rst_n = 1'b1;
    step();
    // diagonal walk
    mem[2][2] = 3'd0;
    mem[1][1] = 3'd0;
    model(2, 2);
    chk("pin_diag_n", exp_q.size(), 2);
    chk("pin_diag_r1", exp_q[1].row, 1);
    chk("pin_diag_err", exp_err, 0);
    run_walk(2, 2, 0, 0);
    // mixed walk ending on column underflow
    fill_stop();
    mem[3][1] = 3'd1;
    mem[2][1] = 3'd2;
    mem[2][0] = 3'd0;
    model(3, 1);
    chk("pin_mix_n", exp_q.size(), 3);
    chk("pin_mix_c0", exp_q[0].code, 1);
    chk("pin_mix_c1", exp_q[1].code, 2);
    chk("pin_mix_col2", exp_q[2].col, 0);
    chk("pin_mix_reads", exp_reads, 3);
    run_walk(3, 1, 0, 0);
    // backpressure on the first op
    run_walk(3, 1, 0, 5);
    // immediate stop timing
    fill_stop();
    run_walk(5, 5, 0, 0);
    chk("stop_first_rd", first_rd - start_cyc, 1);
    chk("stop_done", done_at - start_cyc, 3);
    // out of range start
    run_walk(16, 3, 0, 0);
    chk("range_done", done_at - start_cyc, 1);
    chk("range_reads", walk_rd, 0);
    // invalid pointer plus a start while busy
    mem[4][6] = 3'd4;
    model(4, 6);
    chk("pin_inv_err", exp_err, 1);
    run_walk(4, 6, 1, 0);
    // asynchronous reset mid-EMIT
    fill_stop();
    mem[2][2] = 3'd0;
    mem[1][1] = 3'd0;
    model(2, 2);
    ready_hold = 1'b1;
    step();
    start_row_i = 2;
    start_col_i = 2;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 20 && !op_valid_o; k++) step();
    chk("pre_rst_valid", op_valid_o, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", op_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_rd_en", mem_rd_en_o, 0);
    repeat (2) step();
    ready_hold = 1'b0;
    rst_n = 1'b1;
    fill_stop();
    run_walk(1, 1, 0, 0);
    chk("post_rst_done", done_at - start_cyc, 3);
    // randomized matrices, starts and backpressure
    ready_rand = 1'b1;
    for (int w = 0; w < 60; w++) begin
      for (int i = 0; i < QL; i++)
        for (int j = 0; j < RL; j++) begin
          x = $urandom_range(0, 99);
          mem[i][j] = x < 30 ? 3'd0 : x < 60 ? 3'd1 : x < 90 ? 3'd2 : x < 97 ? 3'd7 : 3'(3 + x % 4);
        end
      r = $urandom_range(0, 99) < 8 ? $urandom_range(16, 31) : $urandom_range(0, 15);
      c = $urandom_range(0, 99) < 8 ? $urandom_range(16, 31) : $urandom_range(0, 15);
      run_walk(r, c, $urandom_range(0, 3) == 0, 0);
    end
    ready_rand = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
